// File: rtl/hazard_pkg.sv
// Shared types and RISC-V instruction field positions for the
// three-stage pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_t;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_FW  = 5;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: cycles until the register's pending result
// becomes forwardable. A load beats the decrement in the same cycle.
module sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ld,
    input  logic [LAT_W-1:0] i_val,
    output logic [LAT_W-1:0] o_cnt
);

    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller: per-register pending scoreboard driving stall,
// E-stage forwarding selects and a multi-cycle branch flush.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS       = 32,
    parameter int LAT_W       = 3,
    parameter int LOAD_LAT    = 2,
    parameter int CSR_LAT     = 1,
    parameter int MDU_LAT     = 4,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir_d,
    input  logic        use_rs1_d,
    input  logic        use_rs2_d,
    input  logic        reg_wr_d,
    input  logic [1:0]  wb_sel_d,
    input  logic        mdu_d,
    input  logic        valid_d,
    input  logic        br_taken_e,
    output logic        for_a,
    output logic        for_b,
    output logic        stall,
    output logic        stall_wm,
    output logic        flush,
    output logic        sb_busy
);

    localparam int RW = $clog2(NREGS);
    localparam int FW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    logic [RW-1:0]    w_rs1, w_rs2, w_rd;
    logic [RW-1:0]    r_rd_e;
    logic             r_wr_e;
    logic [FW-1:0]    r_fcnt;
    logic [LAT_W-1:0] w_pend [NREGS];
    logic [LAT_W-1:0] w_lat;
    wb_sel_t          w_wb;
    logic             w_src1, w_src2, w_haz1, w_haz2, w_waw;
    logic             w_flush, w_stall, w_issue, w_issue_wr, w_busy;
    logic             w_unused_ir;

    assign w_rs1 = ir_d[RS1_LSB +: RW];
    assign w_rs2 = ir_d[RS2_LSB +: RW];
    assign w_rd  = ir_d[RD_LSB  +: RW];
    assign w_wb  = wb_sel_t'(wb_sel_d);
    assign w_unused_ir = ^{ir_d[31:25], ir_d[14:12], ir_d[6:0]};

    // MDU overrides the writeback class latency
    always_comb begin
        w_lat = '0;
        if (mdu_d) begin
            w_lat = LAT_W'(MDU_LAT);
        end else begin
            case (w_wb)
                WB_LOAD: w_lat = LAT_W'(LOAD_LAT);
                WB_CSR:  w_lat = LAT_W'(CSR_LAT);
                default: w_lat = '0;
            endcase
        end
    end

    assign w_src1 = valid_d & use_rs1_d & (w_rs1 != '0);
    assign w_src2 = valid_d & use_rs2_d & (w_rs2 != '0);
    assign w_haz1 = w_src1 & (w_pend[w_rs1] != '0);
    assign w_haz2 = w_src2 & (w_pend[w_rs2] != '0);
    assign w_waw  = valid_d & reg_wr_d & (w_rd != '0)
                  & (w_pend[w_rd] > w_lat);

    assign w_flush    = br_taken_e | (r_fcnt != '0);
    assign w_stall    = (w_haz1 | w_haz2 | w_waw) & ~w_flush;
    assign w_issue    = valid_d & ~w_stall & ~w_flush;
    assign w_issue_wr = w_issue & reg_wr_d & (w_rd != '0);

    assign w_pend[0] = '0;
    for (genvar g = 1; g < NREGS; g++) begin : g_pend
        sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .i_ld  (w_issue_wr && (w_rd == RW'(g))),
            .i_val (w_lat),
            .o_cnt (w_pend[g])
        );
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy = w_busy | (w_pend[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_e <= '0;
            r_wr_e <= 1'b0;
        end else begin
            r_wr_e <= w_issue_wr;
            if (w_issue_wr) begin
                r_rd_e <= w_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if (br_taken_e) begin
            r_fcnt <= FW'(FLUSH_DEPTH - 1);
        end else if (r_fcnt != '0) begin
            r_fcnt <= r_fcnt - 1'b1;
        end
    end

    // a still-pending source reads neither E nor the regfile
    assign for_a = w_src1 & ~w_haz1 & r_wr_e & (w_rs1 == r_rd_e) & ~w_stall;
    assign for_b = w_src2 & ~w_haz2 & r_wr_e & (w_rs2 == r_rd_e) & ~w_stall;

    assign stall    = w_stall;
    assign stall_wm = w_stall;
    assign flush    = w_flush;
    assign sb_busy  = w_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table, async-reset sequence and randomized run against
// a behavioural scoreboard model for hazard_scoreboard.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir_d = '0;
    logic        use_rs1_d = 0, use_rs2_d = 0, reg_wr_d = 0;
    logic [1:0]  wb_sel_d = '0;
    logic        mdu_d = 0, valid_d = 0, br_taken_e = 0;
    logic        for_a, for_b, stall, stall_wm, flush, sb_busy;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FLUSH_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_d       (ir_d),
        .use_rs1_d  (use_rs1_d),
        .use_rs2_d  (use_rs2_d),
        .reg_wr_d   (reg_wr_d),
        .wb_sel_d   (wb_sel_d),
        .mdu_d      (mdu_d),
        .valid_d    (valid_d),
        .br_taken_e (br_taken_e),
        .for_a      (for_a),
        .for_b      (for_b),
        .stall      (stall),
        .stall_wm   (stall_wm),
        .flush      (flush),
        .sb_busy    (sb_busy)
    );

    typedef struct {
        logic [31:0] ir;
        logic        u1, u2, wr;
        logic [1:0]  ws;
        logic        mdu, v, br;
        logic [5:0]  exp;
    } vec_t;

    vec_t tbl [20];
    int   nvec = 0;
    int   nerr = 0;

    int   m_pend [32];
    int   m_rde;
    bit   m_wre;
    int   m_fcnt;

    function automatic logic [31:0] mk(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h13};
    endfunction

    function automatic vec_t mkv(logic [31:0] ir, logic u1, logic u2,
                                 logic wr, logic [1:0] ws, logic mdu,
                                 logic v, logic br, logic fa, logic fb,
                                 logic st, logic fl, logic bz);
        vec_t x;
        x.ir = ir; x.u1 = u1; x.u2 = u2; x.wr = wr; x.ws = ws;
        x.mdu = mdu; x.v = v; x.br = br;
        x.exp = {fa, fb, st, st, fl, bz};
        return x;
    endfunction

    task automatic apply(input vec_t x);
        ir_d = x.ir; use_rs1_d = x.u1; use_rs2_d = x.u2;
        reg_wr_d = x.wr; wb_sel_d = x.ws; mdu_d = x.mdu;
        valid_d = x.v; br_taken_e = x.br;
    endtask

    task automatic chk(input string nm, input logic [5:0] exp);
        logic [5:0] got;
        got = {for_a, for_b, stall, stall_wm, flush, sb_busy};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b (fa fb st swm fl busy)",
                     nm, got, exp);
        end
    endtask

    function automatic int m_lat();
        if (mdu_d) return 4;
        if (wb_sel_d == 2'b01) return 2;
        if (wb_sel_d == 2'b11) return 1;
        return 0;
    endfunction

    function automatic logic [5:0] m_exp(output bit issue);
        int  rs1, rs2, rd;
        bit  h1, h2, waw, fl, st, fa, fb, bz;
        rs1 = int'(ir_d[19:15]);
        rs2 = int'(ir_d[24:20]);
        rd  = int'(ir_d[11:7]);
        h1  = valid_d && use_rs1_d && rs1 != 0 && m_pend[rs1] > 0;
        h2  = valid_d && use_rs2_d && rs2 != 0 && m_pend[rs2] > 0;
        waw = valid_d && reg_wr_d && rd != 0 && m_pend[rd] > m_lat();
        fl  = br_taken_e || m_fcnt > 0;
        st  = (h1 || h2 || waw) && !fl;
        fa  = valid_d && use_rs1_d && rs1 != 0 && m_pend[rs1] == 0
              && m_wre && rs1 == m_rde && !st;
        fb  = valid_d && use_rs2_d && rs2 != 0 && m_pend[rs2] == 0
              && m_wre && rs2 == m_rde && !st;
        bz  = 0;
        foreach (m_pend[i]) if (m_pend[i] > 0) bz = 1;
        issue = valid_d && !st && !fl;
        return {fa, fb, st, st, fl, bz};
    endfunction

    task automatic m_step(input bit issue);
        int rd;
        rd = int'(ir_d[11:7]);
        foreach (m_pend[i]) if (m_pend[i] > 0) m_pend[i]--;
        if (issue && reg_wr_d && rd != 0) begin
            m_pend[rd] = m_lat();
            m_rde = rd;
            m_wre = 1;
        end else begin
            m_wre = 0;
        end
        if (br_taken_e) m_fcnt = FD - 1;
        else if (m_fcnt > 0) m_fcnt--;
    endtask

    task automatic m_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_rde = 0; m_wre = 0; m_fcnt = 0;
    endtask

    initial begin
        vec_t       r;
        logic [5:0] e;
        bit         iss;

        tbl[0]  = mkv(mk(5,0,0), 1,0,1,2'd0,0,1,0, 0,0,0,0,0);
        tbl[1]  = mkv(mk(6,5,5), 1,1,1,2'd0,0,1,0, 1,1,0,0,0);
        tbl[2]  = mkv(mk(7,2,0), 1,0,1,2'd1,0,1,0, 0,0,0,0,0);
        tbl[3]  = mkv(mk(8,7,0), 1,1,1,2'd0,0,1,0, 0,0,1,0,1);
        tbl[4]  = mkv(mk(8,7,0), 1,1,1,2'd0,0,1,0, 0,0,1,0,1);
        tbl[5]  = mkv(mk(8,7,0), 1,1,1,2'd0,0,1,0, 0,0,0,0,0);
        tbl[6]  = mkv(mk(1,0,0), 1,0,1,2'd1,0,1,0, 0,0,0,0,0);
        tbl[7]  = mkv(mk(0,2,1), 1,1,0,2'd0,0,1,0, 0,0,1,0,1);
        tbl[8]  = mkv(mk(0,2,1), 1,1,0,2'd0,0,1,0, 0,0,1,0,1);
        tbl[9]  = mkv(mk(0,2,1), 1,1,0,2'd0,0,1,0, 0,0,0,0,0);
        tbl[10] = mkv(mk(3,0,0), 1,0,1,2'd0,1,1,0, 0,0,0,0,0);
        tbl[11] = mkv(mk(3,0,0), 1,0,1,2'd0,0,1,0, 0,0,1,0,1);
        tbl[12] = mkv(mk(3,0,0), 1,0,1,2'd0,0,1,0, 0,0,1,0,1);
        tbl[13] = mkv(mk(3,0,0), 1,0,1,2'd0,0,1,0, 0,0,1,0,1);
        tbl[14] = mkv(mk(3,0,0), 1,0,1,2'd0,0,1,0, 0,0,1,0,1);
        tbl[15] = mkv(mk(3,0,0), 1,0,1,2'd0,0,1,0, 0,0,0,0,0);
        tbl[16] = mkv(mk(7,0,0), 1,0,1,2'd1,0,1,0, 0,0,0,0,0);
        tbl[17] = mkv(mk(8,7,0), 1,0,1,2'd1,0,1,1, 0,0,0,1,1);
        tbl[18] = mkv(mk(8,7,0), 1,0,1,2'd1,0,1,0, 0,0,0,1,1);
        tbl[19] = mkv(mk(9,8,8), 1,1,1,2'd0,0,1,0, 0,0,0,0,0);

        #1 chk("reset", 6'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i]);
            #2 chk($sformatf("tbl%0d", i), tbl[i].exp);
            @(negedge clk);
        end

        apply(mkv(mk(7,0,0), 1,0,1,2'd1,0,1,0, 0,0,0,0,0));
        #2 chk("rst_lw", 6'b000000);
        @(negedge clk);
        apply(mkv(mk(8,7,0), 1,0,1,2'd0,0,1,1, 0,0,0,0,0));
        #2 chk("rst_flush", 6'b000011);
        #1 br_taken_e = 1'b0;
        rst_n = 1'b0;
        #1 chk("async_rst", 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        #2 chk("post_rst_dep", 6'b000000);
        @(negedge clk);

        rst_n = 1'b0;
        m_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r.ir = $urandom;
            r.ir[11:7]  = 5'($urandom_range(0, 7));
            r.ir[19:15] = 5'($urandom_range(0, 7));
            r.ir[24:20] = 5'($urandom_range(0, 7));
            r.u1  = 1'($urandom);
            r.u2  = 1'($urandom);
            r.wr  = 1'($urandom);
            r.ws  = 2'($urandom);
            r.mdu = ($urandom_range(0, 7) == 0);
            r.v   = ($urandom_range(0, 7) != 0);
            r.br  = ($urandom_range(0, 9) == 0);
            r.exp = '0;
            apply(r);
            #2;
            e = m_exp(iss);
            chk($sformatf("rnd%0d", i), e);
            m_step(iss);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
